// File: rtl/operand_bypass_sb.sv
// Operand bypass (EX/MEM > WB > RF) and pending-write scoreboard feeding the E stage.
// Optional BYPASS_STATS_EN adds saturating stall/forward counters.
module operand_bypass_sb #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int NPORTS = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [NPORTS*REG_AW-1:0]   rs_addr,
  input  logic [NPORTS*DATA_W-1:0]   rf_data,
  input  logic [NPORTS-1:0]          rs_used,
  input  logic                       wr_en,
  input  logic [REG_AW-1:0]          wr_addr,
  input  logic                       m_valid,
  input  logic [REG_AW-1:0]          m_addr,
  input  logic [DATA_W-1:0]          m_data,
  input  logic                       w_valid,
  input  logic [REG_AW-1:0]          w_addr,
  input  logic [DATA_W-1:0]          w_data,
  output logic                       op_valid,
  output logic [NPORTS*DATA_W-1:0]   op_data,
  output logic [NPORTS*2-1:0]        fwd_sel
`ifdef BYPASS_STATS_EN
  ,
  output logic [31:0]                stat_stall,
  output logic [31:0]                stat_fwd_m,
  output logic [31:0]                stat_fwd_w
`endif
);

  localparam int NREG = 1 << REG_AW;

  logic [NREG-1:0]          r_pending;
  logic [NREG-1:0]          w_pend_eff;
  logic                     w_clr_m;
  logic                     w_waw;
  logic                     w_accept;
  logic [NPORTS-1:0]        w_raw;
  logic [REG_AW-1:0]        w_rs;
  logic [NPORTS*DATA_W-1:0] w_sel_data;
  logic [NPORTS*2-1:0]      w_sel;

  assign w_clr_m = m_valid && (m_addr != '0);

  always_comb begin
    w_pend_eff = r_pending;
    if (w_clr_m) w_pend_eff[m_addr] = 1'b0;
    w_sel_data = '0;
    w_sel      = '0;
    w_raw      = '0;
    w_rs       = '0;
    for (int p = 0; p < NPORTS; p++) begin
      w_rs = rs_addr[p*REG_AW +: REG_AW];
      if (m_valid && (m_addr == w_rs) && (w_rs != '0)) begin
        w_sel_data[p*DATA_W +: DATA_W] = m_data;
        w_sel[p*2 +: 2]                = 2'b10;
      end else if (w_valid && (w_addr == w_rs) && (w_rs != '0)) begin
        w_sel_data[p*DATA_W +: DATA_W] = w_data;
        w_sel[p*2 +: 2]                = 2'b01;
      end else begin
        w_sel_data[p*DATA_W +: DATA_W] = rf_data[p*DATA_W +: DATA_W];
        w_sel[p*2 +: 2]                = 2'b00;
      end
      // A stalled consumer is released in the very cycle its producer appears on m.
      w_raw[p] = rs_used[p] && w_pend_eff[w_rs] && !(m_valid && (m_addr == w_rs));
    end
  end

  assign w_waw       = wr_en && (wr_addr != '0) && w_pend_eff[wr_addr];
  assign issue_ready = !(|w_raw) && !w_waw;
  assign w_accept    = issue_valid && issue_ready;

  // Scoreboard: the set from an accepted issue overrides a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      if (w_clr_m) r_pending[m_addr] <= 1'b0;
      if (w_accept && wr_en && (wr_addr != '0)) r_pending[wr_addr] <= 1'b1;
    end
  end

  // E-stage register boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid <= 1'b0;
      op_data  <= '0;
      fwd_sel  <= '0;
    end else begin
      op_valid <= w_accept;
      if (w_accept) begin
        op_data <= w_sel_data;
        fwd_sel <= w_sel;
      end
    end
  end

`ifdef BYPASS_STATS_EN
  logic [2:0] w_nm;
  logic [2:0] w_nw;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [2:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {30'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  always_comb begin
    w_nm = '0;
    w_nw = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (w_sel[p*2 +: 2] == 2'b10) w_nm = w_nm + 3'd1;
      if (w_sel[p*2 +: 2] == 2'b01) w_nw = w_nw + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_stall <= '0;
      stat_fwd_m <= '0;
      stat_fwd_w <= '0;
    end else begin
      if (issue_valid && !issue_ready) stat_stall <= sat_add(stat_stall, 3'd1);
      if (w_accept) begin
        stat_fwd_m <= sat_add(stat_fwd_m, w_nm);
        stat_fwd_w <= sat_add(stat_fwd_w, w_nw);
      end
    end
  end
`endif

endmodule

// File: tb/tb_operand_bypass_sb.sv
// Directed bench for operand_bypass_sb (default parameters, DATA_W=32, REG_AW=5, NPORTS=2).
module tb_operand_bypass_sb;
  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [9:0]  rs_addr;
  logic [63:0] rf_data;
  logic [1:0]  rs_used;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic        m_valid;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        w_valid;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        op_valid;
  logic [63:0] op_data;
  logic [3:0]  fwd_sel;
`ifdef BYPASS_STATS_EN
  logic [31:0] stat_stall;
  logic [31:0] stat_fwd_m;
  logic [31:0] stat_fwd_w;
`endif

  int tests = 0;
  int fails = 0;

  operand_bypass_sb dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .rs_addr(rs_addr), .rf_data(rf_data), .rs_used(rs_used), .wr_en(wr_en),
    .wr_addr(wr_addr), .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data),
    .w_valid(w_valid), .w_addr(w_addr), .w_data(w_data), .op_valid(op_valid),
    .op_data(op_data), .fwd_sel(fwd_sel)
`ifdef BYPASS_STATS_EN
    , .stat_stall(stat_stall), .stat_fwd_m(stat_fwd_m), .stat_fwd_w(stat_fwd_w)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; issue_valid = 0; rs_addr = '0; rf_data = '0; rs_used = '0;
    wr_en = 0; wr_addr = '0; m_valid = 0; m_addr = '0; m_data = '0;
    w_valid = 0; w_addr = '0; w_data = '0;
    #1 rst_n = 1'b0;
    #20;
    chk("rst_op_valid", 64'(op_valid), 64'd0);
    chk("rst_op_data", op_data, 64'd0);
    chk("rst_fwd_sel", 64'(fwd_sel), 64'd0);
    chk("rst_ready", 64'(issue_ready), 64'd1);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Plain RF read of r3
    issue_valid = 1; rs_addr = {5'd0, 5'd3}; rs_used = 2'b01; rf_data = {32'h0, 32'h11};
    #1 chk("rf_ready", 64'(issue_ready), 64'd1);
    tick();
    chk("rf_op_valid", 64'(op_valid), 64'd1);
    chk("rf_op_data", op_data, 64'h0000_0000_0000_0011);
    chk("rf_fwd_sel", 64'(fwd_sel), 64'd0);

    // Producer of r5 (op_data should again be 0x11), then a stalled consumer
    rs_used = 2'b00; wr_en = 1; wr_addr = 5'd5;
    tick();
    chk("prod5_op_data", op_data, 64'h11);
    wr_en = 0; rs_addr = {5'd0, 5'd5}; rs_used = 2'b01; rf_data = {32'h0, 32'hDEAD};
    #1 chk("raw5_ready", 64'(issue_ready), 64'd0);
    tick();
    chk("raw5_op_valid", 64'(op_valid), 64'd0);
    chk("raw5_hold_data", op_data, 64'h11);
    chk("raw5_ready2", 64'(issue_ready), 64'd0);
    tick();
    chk("raw5_op_valid2", 64'(op_valid), 64'd0);
    m_valid = 1; m_addr = 5'd5; m_data = 32'hABCD;
    #1 chk("raw5_release", 64'(issue_ready), 64'd1);
    tick();
    chk("m5_op_valid", 64'(op_valid), 64'd1);
    chk("m5_op_data", op_data, 64'h0000_0000_0000_ABCD);
    chk("m5_fwd_sel", 64'(fwd_sel), 64'b0010);
    m_valid = 0;
    #1 chk("p5_cleared_raw", 64'(issue_ready), 64'd1);
    wr_en = 1; wr_addr = 5'd5; rs_used = 2'b00;
    #1 chk("p5_cleared_waw", 64'(issue_ready), 64'd1);
    issue_valid = 0; wr_en = 0;
    tick();

    // m beats w on the same address; then w alone
    issue_valid = 1; rs_addr = {5'd7, 5'd7}; rs_used = 2'b11; rf_data = {32'h33, 32'h44};
    m_valid = 1; m_addr = 5'd7; m_data = 32'h1; w_valid = 1; w_addr = 5'd7; w_data = 32'h2;
    tick();
    chk("mw_op_data", op_data, {32'h1, 32'h1});
    chk("mw_fwd_sel", 64'(fwd_sel), 64'b1010);
    m_valid = 0;
    tick();
    chk("w_op_data", op_data, {32'h2, 32'h2});
    chk("w_fwd_sel", 64'(fwd_sel), 64'b0101);
    chk("w_op_valid", 64'(op_valid), 64'd1);
    w_valid = 0;

    // WAW on r9, released by same-cycle clear; set wins
    rs_used = 2'b00; wr_en = 1; wr_addr = 5'd9;
    tick();
    #1 chk("waw9_ready", 64'(issue_ready), 64'd0);
    tick();
    chk("waw9_op_valid", 64'(op_valid), 64'd0);
    m_valid = 1; m_addr = 5'd9; m_data = 32'h99;
    #1 chk("waw9_release", 64'(issue_ready), 64'd1);
    tick();
    chk("waw9_accepted", 64'(op_valid), 64'd1);
    m_valid = 0; wr_en = 0; rs_addr = {5'd0, 5'd9}; rs_used = 2'b01;
    #1 chk("p9_still_set", 64'(issue_ready), 64'd0);
    issue_valid = 0;
    #1 chk("ready_no_valid_path", 64'(issue_ready), 64'd0);
    m_valid = 1; m_addr = 5'd9;
    tick();
    m_valid = 0;
    #1 chk("p9_cleared", 64'(issue_ready), 64'd1);

    // Register 0 never forwards or stalls
    issue_valid = 1; rs_addr = {5'd0, 5'd0}; rs_used = 2'b11; rf_data = {32'h0, 32'h55};
    m_valid = 1; m_addr = 5'd0; m_data = 32'hFFFF; wr_en = 1; wr_addr = 5'd0;
    #1 chk("r0_ready", 64'(issue_ready), 64'd1);
    tick();
    chk("r0_op_data", op_data, 64'h55);
    chk("r0_fwd_sel", 64'(fwd_sel), 64'd0);
    m_valid = 0;
    #1 chk("r0_no_waw", 64'(issue_ready), 64'd1);
    tick();
    chk("r0_b2b_valid", 64'(op_valid), 64'd1);

    // Pending r4 and r6, reset during a stall
    rs_used = 2'b00; wr_addr = 5'd4;
    tick();
    wr_addr = 5'd6;
    tick();
    wr_en = 0; rs_addr = {5'd6, 5'd4}; rs_used = 2'b01;
    #1 chk("raw4_ready", 64'(issue_ready), 64'd0);
    tick();
    chk("raw4_op_valid", 64'(op_valid), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_op_valid", 64'(op_valid), 64'd0);
    chk("mid_rst_op_data", op_data, 64'd0);
    chk("mid_rst_ready", 64'(issue_ready), 64'd1);
`ifdef BYPASS_STATS_EN
    chk("mid_rst_stat_stall", 64'(stat_stall), 64'd0);
`endif
    @(negedge clk) rst_n = 1'b1;
    rs_used = 2'b10;
    #1 chk("p6_cleared", 64'(issue_ready), 64'd1);
    tick();
    chk("post_rst_accept", 64'(op_valid), 64'd1);
    issue_valid = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/operand_bypass_sb.md
# operand_bypass_sb

Parametrised operand-bypass and scoreboard stage between decode and execute of the pipelined CPU. For each of NPORTS source operands it selects register-file, writeback or EX/MEM data. A per-register pending scoreboard stalls issue on RAW and WAW hazards against multi-cycle producers. The selected operands are registered into the E stage, with a bubble inserted on stall.

## Interface
Parameters:
- DATA_W, 32, operand width
- REG_AW, 5, register address width (2**REG_AW registers; register 0 hardwired zero)
- NPORTS, 2, number of source operand ports (1..4)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- issue_valid  in  1  decode presents an instruction
- issue_ready  out  1  combinational; instruction accepted this cycle when issue_valid && issue_ready
- rs_addr  in  NPORTS*REG_AW  source register addresses; port p at bits [p*REG_AW +: REG_AW]
- rf_data  in  NPORTS*DATA_W  register-file read data per port
- rs_used  in  NPORTS  port p actually reads rs_addr[p]
- wr_en  in  1  issuing instruction writes a register
- wr_addr  in  REG_AW  destination of issuing instruction
- m_valid, m_addr, m_data  in  1/REG_AW/DATA_W  EX/MEM result bus
- w_valid, w_addr, w_data  in  1/REG_AW/DATA_W  writeback result bus
- op_valid  out  1  E-stage operands valid
- op_data  out  NPORTS*DATA_W  registered selected operands
- fwd_sel  out  NPORTS*2  registered per-port source: 00 rf, 01 w, 10 m

## Operation
- Scoreboard: pending[0..2**REG_AW-1], one bit per register; pending[0] constant 0.
- clr_m = m_valid && m_addr != 0. pend_eff[r] = pending[r] && !(clr_m && m_addr == r).
- Per-port selection, priority m > w > rf:
  - m_valid && m_addr == rs && rs != 0 → m_data, sel 10.
  - else w_valid && w_addr == rs && rs != 0 → w_data, sel 01.
  - else rf_data, sel 00.
- RAW hazard on port p: rs_used[p] && pend_eff[rs_addr[p]] && !(m_valid && m_addr == rs_addr[p]).
- WAW hazard: wr_en && wr_addr != 0 && pend_eff[wr_addr].
- issue_ready = no RAW hazard on any port and no WAW hazard; independent of issue_valid.
- On accept:
  - op_valid <= 1, op_data and fwd_sel <= selected values.
  - If wr_en && wr_addr != 0, pending[wr_addr] <= 1.
- On no accept: op_valid <= 0; op_data and fwd_sel hold.
- clr_m clears pending[m_addr]. A set from a same-cycle accept to the same address wins over the clear.
- w bus never touches the scoreboard. Writes to register 0 are ignored everywhere.

## Timing
- Reset, asynchronous: op_valid=0, op_data=0, fwd_sel=0, all pending=0. issue_ready is 1 while rst_n is low.
- Latency: operands appear on op_data one cycle after the accept edge.
- issue_ready is a combinational function of rs_addr, rs_used, wr_en, wr_addr, m bus and pending. No path from issue_valid.
- A producer must drive m_valid exactly once per pending write. A consumer stalled on X is accepted in the cycle m_valid && m_addr == X, taking m_data.
- Back-to-back issue is sustained at one per cycle when no hazard exists.
- Reset asserted mid-operation discards all pending bits and the E-stage contents immediately.

## Configuration
- BYPASS_STATS_EN defined adds three 32-bit saturating counters, cleared by reset:
  - stat_stall (cycles with issue_valid && !issue_ready)
  - stat_fwd_m (accepted port selections of m)
  - stat_fwd_w (accepted port selections of w)
- The counters are exposed as outputs stat_stall, stat_fwd_m, stat_fwd_w, each 32 bits.
- Undefined: the counters and their ports are absent, with no other behavioural difference.

## Test plan
- Reset, then issue rs=3, rs_used=1, rf_data=0x11, no buses active → next cycle op_valid=1, op_data=0x11, fwd_sel=00.
- Issue wr r5, then consumer of r5 → issue_ready=0 and op_valid=0 each stalled cycle. Drive m_valid, m_addr=5, m_data=0xABCD → accepted that cycle, op_data=0xABCD, sel=10, pending[5]=0.
- m_addr=w_addr=7 with m_data=0x1, w_data=0x2, rs=7 → op_data=0x1, sel=10. Repeat with m_valid=0 → op_data=0x2, sel=01.
- Pending r9, issue with wr r9 → WAW stall. Same cycle m clears r9 → accepted, pending[9] remains 1.
- rs=0 with m_addr=0, m_valid=1, m_data=0xFFFF → rf_data selected, sel=00, no stall. wr r0 leaves scoreboard unchanged.
- Pending r4 and r6, assert rst_n=0 mid-stall → pending cleared, op_valid=0, issue_ready=1. With BYPASS_STATS_EN, stat_stall=0.
